// File: rtl/piso_serializer_tx.sv
// piso_serializer_tx: parallel-in/serial-out transmitter for the bit-serial link.
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per
// enabled clock on SOUT/SVALID/SFRAME, optionally followed by an even-parity bit.
module piso_serializer_tx #(
  parameter int WIDTH     = 8,  // data word width, 2..32
  parameter int MSB_FIRST = 1,  // 1: DIN[WIDTH-1] leaves first, 0: DIN[0] leaves first
  parameter int PARITY    = 0   // 1: append one even-parity bit after the data bits
) (
  input  logic             CK,
  input  logic             CDN,
  input  logic             SP,
  input  logic             SR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DVALID,
  output logic             DREADY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             SFRAME,
  output logic             BUSY
);

  // Frame length in bits and the counter values that matter inside a frame.
  localparam int L  = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam int CW = $clog2(L);
  localparam logic [CW-1:0] LAST_BIT  = CW'(L - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;          // data bits not yet presented move toward the output end
  logic [CW-1:0]    cnt;         // index of the bit currently on SOUT
  logic             par;         // even parity of the word being sent
  logic [WIDTH-1:0] sr_shifted;
  logic             first_bit;
  logic             next_bit;
  logic             at_last;
  logic             transfer;

  // Handshake decode, status and next-bit selection.
  // NOTE: every signal written in an always_comb gets an unconditional assignment,
  // so no path leaves it holding its old value (which would infer a latch).
  always_comb begin
    at_last    = (state == SHIFT) && (cnt == LAST_BIT);
    DREADY     = (state == IDLE) || at_last;
    BUSY       = (state == SHIFT);
    transfer   = DVALID && DREADY && SP;
    sr_shifted = (MSB_FIRST != 0) ? (sr << 1) : (sr >> 1);
    first_bit  = (MSB_FIRST != 0) ? DIN[WIDTH-1] : DIN[0];
    next_bit   = (MSB_FIRST != 0) ? sr_shifted[WIDTH-1] : sr_shifted[0];
    // After the last data bit the trailer bit replaces the shifted data.
    if ((PARITY != 0) && (cnt == LAST_DATA)) begin
      next_bit = par;
    end
  end

  // Frame sequencer: load on transfer, shift while enabled, clear at frame end.
  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      // NOTE: the shift register is reset as well, so a reset leaves no stale
      // word that could be observed in simulation or scan.
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      par    <= 1'b0;
      SOUT   <= 1'b0;
      SVALID <= 1'b0;
      SFRAME <= 1'b0;
    end else if (SR) begin
      // Synchronous clear wins over everything, including a pending transfer.
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      par    <= 1'b0;
      SOUT   <= 1'b0;
      SVALID <= 1'b0;
      SFRAME <= 1'b0;
    end else if (SP) begin
      if (transfer) begin
        // New word: from IDLE or directly after the last bit of the previous frame.
        state  <= SHIFT;
        sr     <= DIN;
        cnt    <= '0;
        par    <= ^DIN;
        SOUT   <= first_bit;
        SVALID <= 1'b1;
        SFRAME <= 1'b1;
      end else if (state == SHIFT) begin
        if (at_last) begin
          state  <= IDLE;
          SOUT   <= 1'b0;
          SVALID <= 1'b0;
          SFRAME <= 1'b0;
        end else begin
          sr     <= sr_shifted;
          cnt    <= cnt + CW'(1);
          SOUT   <= next_bit;
          SFRAME <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer_tx.sv
// Self-checking bench for piso_serializer_tx. Two configurations run side by side:
// (WIDTH=8, MSB first, no parity) and (WIDTH=8, LSB first, even parity). Each has a
// driver, a reference model that turns every accepted word into its expected bit
// stream, and a monitor that consumes one expected bit per enabled valid cycle.
module tb_piso_serializer_tx;

  localparam int W = 8;

  typedef struct packed {
    logic b;  // expected SOUT
    logic f;  // expected SFRAME
  } exp_bit_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int MSB = (g == 0) ? 1 : 0;
    localparam int PAR = (g == 1) ? 1 : 0;
    localparam int L   = W + PAR;

    logic         cdn, sp, sr, dvalid;
    logic [W-1:0] din;
    logic         dready, sout, svalid, sframe, busy;
    exp_bit_t     exp_q[$];
    int           acc;
    int           sp_mode;
    bit           done;

    piso_serializer_tx #(
      .WIDTH    (W),
      .MSB_FIRST(MSB),
      .PARITY   (PAR)
    ) dut (
      .CK    (clk),
      .CDN   (cdn),
      .SP    (sp),
      .SR    (sr),
      .DIN   (din),
      .DVALID(dvalid),
      .DREADY(dready),
      .SOUT  (sout),
      .SVALID(svalid),
      .SFRAME(sframe),
      .BUSY  (busy)
    );

    // Reference model: a word becomes L expected bits in transmit order.
    function automatic void push_frame(input logic [W-1:0] w);
      exp_bit_t e;
      for (int i = 0; i < W; i++) begin
        e.b = (MSB != 0) ? w[W-1-i] : w[i];
        e.f = (i == 0);
        exp_q.push_back(e);
      end
      if (PAR != 0) begin
        e.b = ^w;
        e.f = 1'b0;
        exp_q.push_back(e);
      end
    endfunction

    // Monitor: runs on the falling edge, away from the active edge.
    always @(negedge clk) begin : monitor
      int   n;
      logic ready_model;
      if (!cdn) exp_q.delete();
      n = exp_q.size();
      ready_model = (n <= 1);
      if (n == 0) begin
        check($sformatf("c%0d_svalid_idle", g), svalid, 0);
        check($sformatf("c%0d_sout_idle", g), sout, 0);
        check($sformatf("c%0d_sframe_idle", g), sframe, 0);
      end else begin
        check($sformatf("c%0d_svalid", g), svalid, 1);
        check($sformatf("c%0d_sout", g), sout, exp_q[0].b);
        check($sformatf("c%0d_sframe", g), sframe, exp_q[0].f);
      end
      check($sformatf("c%0d_dready", g), dready, ready_model);
      check($sformatf("c%0d_busy", g), busy, (n != 0));
      if (cdn) begin
        if (sr) begin
          exp_q.delete();
        end else if (sp) begin
          if (n != 0) void'(exp_q.pop_front());
          if (dvalid && ready_model) begin
            push_frame(din);
            acc++;
          end
        end
      end
    end

    // Clock-enable pattern: 0 always on, 1 toggling, 2 random (~70% on).
    initial begin
      sp = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        case (sp_mode)
          0:       sp = 1'b1;
          1:       sp = ~sp;
          default: sp = ($urandom_range(0, 9) < 7);
        endcase
      end
    end

    // Offer a word and hold it until the model records its acceptance.
    task automatic send(input logic [W-1:0] w);
      int start;
      int waited;
      start  = acc;
      waited = 0;
      din    = w;
      dvalid = 1'b1;
      while (acc == start && waited < 500) begin
        @(posedge clk);
        #1;
        waited++;
      end
      if (acc == start) begin
        checks++;
        errors++;
        $display("FAIL c%0d_send_timeout: word %0h still pending after %0d cycles, expected acceptance", g, w, waited);
      end
    endtask

    task automatic idle(input int n);
      dvalid = 1'b0;
      for (int i = 0; i < n; i++) begin
        din = W'($urandom);
        @(posedge clk);
        #1;
      end
    endtask

    // Stimulus sequence for this configuration.
    initial begin
      cdn = 1'b0; sr = 1'b0; dvalid = 1'b0; din = '0;
      sp_mode = 0; acc = 0; done = 1'b0;
      repeat (3) @(posedge clk);
      #1 cdn = 1'b1;
      idle(2);

      // Single word, then back-to-back pair with DVALID held high.
      send((g == 0) ? 8'hA5 : 8'h07);
      idle(12);
      send(8'h01);
      send(8'h80);
      idle(20);

      // Enable toggling during a frame: every bit held for two cycles.
      sp_mode = 1;
      send(8'hF0);
      idle(24);
      sp_mode = 0;
      idle(2);

      // Asynchronous reset in the middle of a frame (while bit 3 is on SOUT).
      send(8'h3C);
      dvalid = 1'b0;
      repeat (3) @(posedge clk);
      #2 cdn = 1'b0;
      #1;
      check($sformatf("c%0d_arst_sout", g), sout, 0);
      check($sformatf("c%0d_arst_svalid", g), svalid, 0);
      check($sformatf("c%0d_arst_sframe", g), sframe, 0);
      check($sformatf("c%0d_arst_busy", g), busy, 0);
      check($sformatf("c%0d_arst_dready", g), dready, 1);
      @(posedge clk);
      #1 cdn = 1'b1;
      idle(2);
      send(8'h5A);
      idle(12);

      // Synchronous clear coincident with an offered word in IDLE.
      din = 8'hFF; dvalid = 1'b1; sr = 1'b1;
      @(posedge clk);
      #1 sr = 1'b0; dvalid = 1'b0;
      idle(3);

      // Synchronous clear in the middle of a frame.
      send(8'hC3);
      dvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1 sr = 1'b1;
      @(posedge clk);
      #1 sr = 1'b0;
      idle(3);

      // Randomized traffic: random words, gaps, enables and occasional clears.
      sp_mode = 2;
      for (int i = 0; i < 150; i++) begin
        send(W'($urandom));
        if ($urandom_range(0, 19) == 0) begin
          dvalid = 1'b0;
          repeat ($urandom_range(1, 5)) @(posedge clk);
          #1 sr = 1'b1;
          @(posedge clk);
          #1 sr = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          idle($urandom_range(1, 4));
        end
      end
      sp_mode = 0;
      idle(L + 6);
      done = 1'b1;
    end
  end

  // Wait for both configurations, bounded, then report.
  initial begin
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      if (cfg[0].done && cfg[1].done) break;
    end
    if (!(cfg[0].done && cfg[1].done)) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: done flags %0b%0b, expected 11", cfg[1].done, cfg[0].done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
